edge_threshold: RTL and testbench
=================================

// Module: edge_threshold
// PURPOSE
//  Downstream consumer of the gradient-magnitude stage. Takes a raster stream of unsigned
//  magnitudes, one per pixel, and emits a 1-bit edge map.
//  - Threshold adapts per frame: it is derived from the previous frame's peak magnitude.
//  - Tracks raster position with column/row counters and flags the last pixel of each frame.
//  - Sits between the magnitude stage and the edge-map packer/UART stage.
// PARAMETERS
//  Width       15   magnitude width (unsigned); matches magnitude-stage output
//  FrameW      160  pixels per line, >= 2
//  FrameH      120  lines per frame, >= 2
//  ThreshShift 2    threshold = prev_frame_max >> ThreshShift
//  MinThresh   16   floor on threshold; Width bits
//  InitThresh  64   threshold used from reset until the first frame completes
// PORTS
//  clk_i     in   1      clock, rising edge
//  rst_ni    in   1      synchronous active-low reset
//  valid_i   in   1      upstream magnitude valid
//  mag_i     in   Width  unsigned gradient magnitude
//  ready_o   out  1      accept upstream beat
//  valid_o   out  1      edge bit valid
//  edge_o    out  1      1 = edge (mag >= active threshold)
//  last_o    out  1      qualifies edge_o: last pixel of frame (col FrameW-1, row FrameH-1)
//  ready_i   in   1      downstream accepts
//  thresh_o  out  Width  currently active threshold (debug/telemetry)
// BEHAVIOUR
//  - Handshake: beat moves when valid&ready. Single registered output slot, latency 1.
//    - ready_o = !valid_o | ready_i (combinational pass-through of ready_i; no bubble).
//    - valid_o/edge_o/last_o stay stable while valid_o & !ready_i.
//  - Reset (rst_ni=0 at clk edge) clears all state:
//    - valid_o=0, edge_o=0, last_o=0.
//    - col=0, row=0, run_max=0.
//    - thresh=thresh_o=InitThresh.
//  - Reset mid-frame discards the partial frame; the next accepted beat is pixel (0,0).
//  - Per accepted beat:
//    - edge_o <= (mag_i >= thresh), unsigned compare, full Width.
//    - last_o <= (col==FrameW-1 && row==FrameH-1).
//    - run_max <= max(run_max, mag_i).
//  - Counters on accepted beat:
//    - col wraps FrameW-1 -> 0 and increments row.
//    - row wraps FrameH-1 -> 0 on the last pixel. No other wrap.
//  - Frame boundary, on acceptance of the last pixel:
//    - cand = max(run_max, mag_i) >> ThreshShift (mag_i of the last pixel included).
//    - thresh <= (cand < MinThresh) ? MinThresh : cand.
//    - run_max <= 0.
//    - The last pixel itself is compared against the OLD threshold. The new threshold
//      applies from the first pixel of the next frame.
//  - thresh_o = thresh register. Changes only at frame boundaries or on reset.
//  - Peak saturates naturally at 2^Width-1; no overflow, since max never grows width.
//  - No internal buffering beyond the one output slot; upstream stalls via ready_o.
// CONFIGURATION
//  EDGE_BORDER_SUPPRESS_EN
//   - Defined: edge_o forced to 0 for pixels with col==0, col==FrameW-1, row==0 or
//     row==FrameH-1 (Sobel window invalid there).
//   - Border pixels still update run_max, counters and last_o.
//   - Undefined: no suppression; edge_o is purely the threshold compare.
// TESTING (bench uses FrameW=4, FrameH=3, ThreshShift=2, MinThresh=16, InitThresh=64)
//  1 Reset, then stream 12 mags all =64 with ready_i=1:
//    - edge_o=1 on every beat; last_o=1 only on beat 12; latency 1 cycle.
//    - Afterwards thresh_o=16 (64>>2=16, equal to floor).
//  2 Frame 1 peak 400 at last pixel, rest 10:
//    - Last pixel edge_o=1 (400>=64).
//    - thresh_o=100 from next frame; frame-2 mag 99 -> 0, mag 100 -> 1.
//  3 Frame of all zeros -> thresh_o=MinThresh=16; next-frame mag 15 -> 0, mag 16 -> 1.
//  4 Backpressure: hold ready_i=0 for 5 cycles with valid_i=1:
//    - ready_o=0 while valid_o=1; outputs stable; no beat lost or duplicated.
//    - Counters advance exactly once per accepted beat (last_o still on 12th).
//  5 Assert rst_ni=0 for 1 cycle after 7 beats:
//    - valid_o=0, thresh_o=64.
//    - Next 12 beats form a full frame with last_o on the 12th.
//  6 With EDGE_BORDER_SUPPRESS_EN, all mags=1000:
//    - edge_o=1 only at (1,1) and (2,1); others 0.
//    - thresh_o=250 after the frame.

Source files
------------

// File: rtl/edge_threshold.sv
// edge_threshold: 1-bit edge map from a magnitude raster; threshold adapts per frame (EDGE_BORDER_SUPPRESS_EN zeroes border edges).
// Latency 1 cycle, single output slot; ready_o = !valid_o | ready_i, so upstream stalls only while the slot is held.
module edge_threshold #(
  parameter int Width       = 15,
  parameter int FrameW      = 160,
  parameter int FrameH      = 120,
  parameter int ThreshShift = 2,
  parameter int MinThresh   = 16,
  parameter int InitThresh  = 64
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  input  logic [Width-1:0] mag_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic             edge_o,
  output logic             last_o,
  input  logic             ready_i,
  output logic [Width-1:0] thresh_o
);

  localparam int CW = (FrameW > 1) ? $clog2(FrameW) : 1;
  localparam int RW = (FrameH > 1) ? $clog2(FrameH) : 1;
  localparam logic [CW-1:0]    ColLast = CW'(FrameW - 1);
  localparam logic [RW-1:0]    RowLast = RW'(FrameH - 1);
  localparam logic [Width-1:0] MinT    = Width'(MinThresh);
  localparam logic [Width-1:0] InitT   = Width'(InitThresh);

  logic             r_valid;
  logic             r_edge;
  logic             r_last;
  logic [CW-1:0]    r_col;
  logic [RW-1:0]    r_row;
  logic [Width-1:0] r_run_max;
  logic [Width-1:0] r_thresh;

  logic             w_accept;
  logic             w_col_last;
  logic             w_row_last;
  logic             w_frame_last;
  logic             w_border;
  logic             w_edge;
  logic [Width-1:0] w_max;
  logic [Width-1:0] w_cand;
  logic [Width-1:0] w_new_thresh;

  assign ready_o      = !r_valid | ready_i;
  assign w_accept     = valid_i & ready_o;
  assign w_col_last   = (r_col == ColLast);
  assign w_row_last   = (r_row == RowLast);
  assign w_frame_last = w_col_last & w_row_last;

  // Peak includes the current beat so the last pixel of a frame feeds the new threshold.
  assign w_max        = (mag_i > r_run_max) ? mag_i : r_run_max;
  assign w_cand       = w_max >> ThreshShift;
  assign w_new_thresh = (w_cand < MinT) ? MinT : w_cand;

`ifdef EDGE_BORDER_SUPPRESS_EN
  assign w_border = (r_col == '0) | w_col_last | (r_row == '0) | w_row_last;
`else
  assign w_border = 1'b0;
`endif

  assign w_edge = (mag_i >= r_thresh) & !w_border;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_valid   <= 1'b0;
      r_edge    <= 1'b0;
      r_last    <= 1'b0;
      r_col     <= '0;
      r_row     <= '0;
      r_run_max <= '0;
      r_thresh  <= InitT;
    end else begin
      if (ready_o) begin
        r_valid <= valid_i;
      end
      if (w_accept) begin
        r_edge <= w_edge;
        r_last <= w_frame_last;
        if (w_frame_last) begin
          r_thresh  <= w_new_thresh;
          r_run_max <= '0;
        end else begin
          r_run_max <= w_max;
        end
        if (w_col_last) begin
          r_col <= '0;
          r_row <= w_row_last ? '0 : r_row + RW'(1);
        end else begin
          r_col <= r_col + CW'(1);
        end
      end
    end
  end

  assign valid_o  = r_valid;
  assign edge_o   = r_edge;
  assign last_o   = r_last;
  assign thresh_o = r_thresh;

endmodule

// File: tb/tb_edge_threshold.sv
// tb_edge_threshold: directed frames plus random valid/ready traffic against a pixel-index reference model.
module tb_edge_threshold;
  localparam int W  = 15;
  localparam int FW = 4;
  localparam int FH = 3;
  localparam int NPIX = FW * FH;

  logic         clk = 1'b0;
  logic         rst_ni;
  logic         valid_i;
  logic [W-1:0] mag_i;
  logic         ready_o;
  logic         valid_o;
  logic         edge_o;
  logic         last_o;
  logic         ready_i;
  logic [W-1:0] thresh_o;

  edge_threshold #(
    .Width(W), .FrameW(FW), .FrameH(FH), .ThreshShift(2), .MinThresh(16), .InitThresh(64)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .valid_i(valid_i), .mag_i(mag_i), .ready_o(ready_o),
    .valid_o(valid_o), .edge_o(edge_o), .last_o(last_o), .ready_i(ready_i), .thresh_o(thresh_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: pixel index within the frame, running peak, active threshold.
  int   m_pix, m_max, m_thresh;
  logic e_valid, e_edge, e_last;
  logic [W-1:0] src[$];
  int   stall_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    e_valid = 0; e_edge = 0; e_last = 0;
    m_pix = 0; m_max = 0; m_thresh = 64;
  endtask

  // Called at a negedge; drives one cycle, checks, returns at the next negedge.
  task automatic cycle(input logic rst, input logic v, input logic [W-1:0] m,
                       input logic rdy, output logic acc);
    int col, row, cand;
    logic e_rdy;
    rst_ni = rst; valid_i = v; mag_i = m; ready_i = rdy;
    e_rdy = !e_valid || rdy;
    acc = rst && v && e_rdy;
    #1;
    chk("ready_o", ready_o, e_rdy);
    @(posedge clk);
    if (!rst) begin
      model_reset();
    end else begin
      if (e_rdy) e_valid = v;
      if (acc) begin
        col = m_pix % FW;
        row = m_pix / FW;
        e_edge = (int'(m) >= m_thresh);
`ifdef EDGE_BORDER_SUPPRESS_EN
        if (col == 0 || col == FW - 1 || row == 0 || row == FH - 1) e_edge = 0;
`endif
        e_last = (m_pix == NPIX - 1);
        if (int'(m) > m_max) m_max = int'(m);
        if (e_last) begin
          cand = m_max >> 2;
          m_thresh = (cand < 16) ? 16 : cand;
          m_max = 0;
          m_pix = 0;
        end else begin
          m_pix++;
        end
      end
    end
    @(negedge clk);
    chk("valid_o", valid_o, e_valid);
    chk("thresh_o", thresh_o, m_thresh);
    if (e_valid) begin
      chk("edge_o", edge_o, e_edge);
      chk("last_o", last_o, e_last);
    end
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, '0, 1'b1, a);
  endtask

  // mode 0: valid/ready always high; mode 1: random bubbles and backpressure.
  task automatic drain(input int mode);
    logic a, v, r;
    int budget = 400;
    while (src.size() > 0 && budget > 0) begin
      v = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      r = (mode == 0) ? 1'b1 : ($urandom_range(0, 9) < 7);
      if (stall_cnt > 0) begin
        r = 1'b0; v = 1'b1; stall_cnt--;
      end
      cycle(1'b1, v, src[0], r, a);
      if (a) void'(src.pop_front());
      budget--;
    end
    if (budget == 0) chk("drain_timeout", 1, 0);
  endtask

  task automatic push_n(input int n, input int val);
    for (int i = 0; i < n; i++) src.push_back(W'(val));
  endtask

  logic acc;

  initial begin
    rst_ni = 1'b0; valid_i = 1'b0; mag_i = '0; ready_i = 1'b1;
    model_reset();
    @(negedge clk);
    cycle(1'b0, 1'b0, '0, 1'b1, acc);
    cycle(1'b0, 1'b0, '0, 1'b1, acc);
    chk("rst_valid", valid_o, 0);
    chk("rst_edge", edge_o, 0);
    chk("rst_last", last_o, 0);
    chk("rst_thresh", thresh_o, 64);

    // Uniform 64 frame: every pixel an edge, new threshold lands on the floor.
    push_n(NPIX, 64); drain(0); idle(1);
    chk("t1_thresh", thresh_o, 16);

    // Peak on last pixel: compared against old threshold, new one is 100.
    push_n(NPIX - 1, 10); push_n(1, 400); drain(0); idle(1);
    chk("t2_thresh", thresh_o, 100);
    push_n(1, 99); push_n(1, 100); push_n(NPIX - 2, 0); drain(0); idle(1);
    chk("t2b_thresh", thresh_o, 25);

    // All-zero frame clamps to the floor; check 15/16 around it.
    push_n(NPIX, 0); drain(0); idle(1);
    chk("t3_thresh", thresh_o, 16);
    push_n(1, 15); push_n(1, 16);
    for (int i = 0; i < NPIX - 2; i++) src.push_back(W'($urandom_range(0, 200)));
    drain(0); idle(1);

    // Backpressure: 3 beats, then ready_i low for 5 cycles with valid_i high.
    for (int i = 0; i < 3; i++) src.push_back(W'($urandom_range(0, 300)));
    drain(0);
    stall_cnt = 5;
    for (int i = 0; i < NPIX - 3; i++) src.push_back(W'($urandom_range(0, 300)));
    drain(0); idle(2);

    // Reset mid-frame after 7 beats discards the partial frame.
    for (int i = 0; i < 7; i++) src.push_back(W'($urandom_range(100, 900)));
    drain(0);
    cycle(1'b0, 1'b1, W'(500), 1'b1, acc);
    chk("t5_valid", valid_o, 0);
    chk("t5_thresh", thresh_o, 64);
    for (int i = 0; i < NPIX; i++) src.push_back(W'($urandom_range(0, 400)));
    drain(0); idle(1);

    // Random frames with bubbles and backpressure.
    for (int f = 0; f < 5; f++) begin
      for (int i = 0; i < NPIX; i++)
        src.push_back(($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 32767))
                                                   : W'($urandom_range(0, 300)));
      drain(1);
    end
    idle(2);

    // Settle the threshold, then a uniform 1000 frame (border behaviour per build).
    push_n(NPIX, 64); drain(0);
    push_n(NPIX, 1000); drain(0); idle(1);
    chk("t6_thresh", thresh_o, 250);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
